data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the MIPS core's load/store port. It accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait cycles, and performs a word read or a byte-enabled write on an internal word-addressed RAM. It returns the result on a response channel that the requester can stall. It sits between the datapath's address/write-data/read-data path and the backing store, replacing a zero-latency data memory.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words in the RAM. Must be a power of two, at least 2.
- `LATENCY`, default 2: wait cycles between request acceptance and the access. Range 0–15.
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low. The block is in reset while `reset`=0 at a rising edge.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_be` in 4: byte enables. Bit i enables bits [8i+7:8i]. Ignored for loads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester accepts the response.
- `rsp_rdata` out 32: load data. 0 for stores and for errors.
- `rsp_err` out 1: access was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1.
  - A request is accepted on an edge where `req_valid`=1 and `req_ready`=1.
  - On acceptance, write, addr, wdata and be are captured into registers.
  - Next state is WAIT if `LATENCY`>0, else the access is performed and the next state is RESP.
- WAIT: `req_ready`=0.
  - A down-counter is loaded with `LATENCY`-1 on acceptance and decrements each cycle.
  - When the counter is 0, the access is performed at that edge and the next state is RESP.
- Access:
  - Error if captured addr[1:0]≠0, or word index addr[31:2] ≥ `DEPTH_WORDS`. The full 30-bit index is compared; there is no wrap or aliasing.
  - On error: the RAM is untouched, `rsp_err`=1, `rsp_rdata`=0.
  - Load: `rsp_rdata` = mem[index], `rsp_err`=0.
  - Store: for each i with be[i]=1, mem[index] byte i = wdata byte i. `rsp_rdata`=0, `rsp_err`=0. be=4'b0000 is a legal no-op store with no error.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - On an edge with `rsp_ready`=1, go to IDLE.
- `req_ready` is never asserted in WAIT or RESP. New requests are not buffered. Inputs in those states are ignored.
- Reset:
  - State goes to IDLE and the counter to 0.
  - `req_ready` reads 0 while `reset`=0 and 1 from the first cycle after release.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - RAM contents are not cleared by reset.
  - Reset during WAIT: the pending access is dropped and no write occurs.
  - Reset during RESP: the response is discarded, but a store already performed remains in the RAM.

## Timing
- Acceptance at edge E0. The access occurs at edge E0+`LATENCY`, and `rsp_valid`=1 in the cycle after that edge.
  - `LATENCY`=0: `rsp_valid` in the cycle following E0.
- Response-to-next-request: at least 1 IDLE cycle. Best-case throughput is one request per `LATENCY`+2 cycles.
- Store data is visible to a load accepted after the store's response handshake.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Reset, then store addr 0x00000010, wdata 0xDEADBEEF, be 4'hF, `LATENCY`=2, `rsp_ready`=1 → `rsp_valid` in the 3rd cycle after acceptance, `rsp_err`=0. A following load of 0x10 returns 0xDEADBEEF.
- Store 0x10 with wdata 0x000000AA, be 4'b0001 over the previous contents → a load of 0x10 returns 0xDEADBEAA. A be=0 store leaves it unchanged with `rsp_err`=0.
- Load 0x00000012 (misaligned) and load 0x00000100 with `DEPTH_WORDS`=64 (index 64) → `rsp_err`=1, `rsp_rdata`=0. A store to 0x100 does not alter word 0.
- Hold `rsp_ready`=0 for 5 cycles with a response pending → `rsp_valid`, `rsp_rdata` and `rsp_err` stay constant and `req_ready` stays 0. Raising `rsp_ready` gives IDLE and `req_ready`=1 the next cycle.
- Assert `reset`=0 one cycle after accepting a store to 0x20 (`LATENCY`=2) → after release, a load of 0x20 returns its pre-store value. Outputs read 0 and `req_ready`=0 during reset.
- With `LATENCY`=0, back-to-back loads with `req_valid` held high → response each time the cycle after acceptance, with one accepted request every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS load/store port: one request at a time, fixed wait
// cycles, then a word read or byte-enabled write on an internal word-addressed RAM.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rdy_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_rdata;
    logic [31:0]   rsp_rdata_d;

    // With zero latency the access uses the live request; otherwise the captured copy.
    always_comb begin
        accept = (state_q == StIdle) && rdy_q && req_valid;
        if (state_q == StIdle) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        access      = reset && ((accept && (LATENCY == 0)) ||
                                ((state_q == StWait) && (cnt_q == 4'd0)));
        acc_err     = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_IDX);
        acc_idx     = acc_addr[AW+1:2];
        acc_rdata   = mem[acc_idx];
        rsp_rdata_d = (acc_err || acc_write) ? 32'd0 : acc_rdata;
    end

    // RAM has no reset; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (access && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rdy_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt_q   <= LAT_M1;
                        rdy_q   <= 1'b0;
                        if (access) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (access) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                        rdy_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = rdy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_data_mem_responder;

    localparam int MAXW = 50;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per response handshake.
    always @(negedge clk) begin
        if (reset && rsp_valid[0] && rsp_ready[0]) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected response", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0 rsp_rdata", rsp_rdata[0], e0.rdata);
                chk("dut0 rsp_err", 32'(rsp_err[0]), 32'(e0.err));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && rsp_valid[1] && rsp_ready[1]) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected response", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 rsp_rdata", rsp_rdata[1], e1.rdata);
                chk("dut1 rsp_err", 32'(rsp_err[1]), 32'(e1.err));
            end
        end
    end

    task automatic push_exp(input int d, input logic [31:0] er, input logic ee);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ready(input int d, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < MAXW) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready[d];
        if (!ok) chk("req_ready timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] er, input logic ee, input int stall);
        int  n;
        int  lat;
        bit  ok;
        lat = (d == 0) ? 2 : 0;
        push_exp(d, er, ee);
        @(posedge clk); #1;
        rsp_ready[d] = (stall == 0);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        wait_ready(d, ok);
        if (!ok) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
            return;
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[d] && n < MAXW);
        chk("rsp latency", 32'(n), 32'(lat + 1));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall rsp_valid", 32'(rsp_valid[d]), 32'd1);
                chk("stall rsp_rdata", rsp_rdata[d], er);
                chk("stall rsp_err", 32'(rsp_err[d]), 32'(ee));
                chk("stall req_ready", 32'(req_ready[d]), 32'd0);
            end
            @(posedge clk); #1;
            rsp_ready[d] = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("post rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic chk_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", 32'(req_ready[d]), 32'd0);
            chk("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("reset rsp_rdata", rsp_rdata[d], 32'd0);
            chk("reset rsp_err", 32'(rsp_err[d]), 32'd0);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release req_ready dut0", 32'(req_ready[0]), 32'd1);
        chk("release req_ready dut1", 32'(req_ready[1]), 32'd1);
    endtask

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_be[d]    = 4'd0;
            rsp_ready[d] = 1'b1;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        release_reset();

        // Full store, partial store, no-op store, mixed byte enables.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);
        do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);
        do_req(0, 1'b1, 32'h10, 32'h55667788, 4'b1010, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'h55AD77AA, 1'b0, 0);

        // Misaligned and out-of-range accesses.
        do_req(0, 1'b0, 32'h12, 32'h0,        4'h0, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, 32'h0,  32'h01020304, 4'hF, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h100, 32'h0,       4'h0, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
        do_req(0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h01020304, 1'b0, 0);
        do_req(0, 1'b0, 32'h80000010, 32'h0,  4'h0, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, 32'h13, 32'h12345678, 4'hF, 32'h0, 1'b1, 0);
        do_req(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'h55AD77AA, 1'b0, 0);

        // Requester stalls the response for 5 cycles.
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h55AD77AA, 1'b0, 5);

        // Reset lands on the access edge of a pending store: the store must be dropped.
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFEF00D;
        req_be[0]    = 4'hF;
        wait_ready(0, ok);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        release_reset();
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11223344, 1'b0, 0);

        // Zero-latency instance: store, then back-to-back loads with req_valid held.
        do_req(1, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++) push_exp(1, 32'hA5A5A5A5, 1'b0);
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b req_ready", 32'(req_ready[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("b2b rsp_valid", 32'(rsp_valid[1]), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 6) begin
                @(posedge clk); #1;
                req_valid[1] = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b final rsp_valid", 32'(rsp_valid[1]), 32'd0);

        repeat (2) @(negedge clk);
        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
